// File: rtl/muhu_pkg.sv
// Shared types and default widths for the muhu memory arbiter.
package muhu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned DefaultDataW = 8;

  // One-hot grant bit positions used by the tie-break picker.
  localparam int unsigned GntF = 0;
  localparam int unsigned GntD = 1;

endpackage

// File: rtl/muhu_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module muhu_rr_pick2
  import muhu_pkg::*;
(
  input  logic       req_f,
  input  logic       req_d,
  input  logic       last_d,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_f && req_d) begin
      if (last_d) grant[GntF] = 1'b1;
      else        grant[GntD] = 1'b1;
    end else if (req_f) begin
      grant[GntF] = 1'b1;
    end else if (req_d) begin
      grant[GntD] = 1'b1;
    end
  end

endmodule

// File: rtl/muhu_mem_arbiter.sv
// Arbitrates a fetch and a data requester onto one memory bus, with a bounded
// wait for m_ack. Every output is a register.
module muhu_mem_arbiter
  import muhu_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              win_d_q, win_d_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              f_ack_q, f_ack_d, f_err_q, f_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic [1:0]        grant;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  muhu_rr_pick2 u_pick (
    .req_f  (f_req),
    .req_d  (d_req),
    .last_d (last_d_q),
    .grant  (grant)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d_d   = last_d_q;
    win_d_d    = win_d_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    busy_d     = busy_q;
    f_ack_d    = 1'b0;
    f_err_d    = 1'b0;
    f_rdata_d  = '0;
    d_ack_d    = 1'b0;
    d_err_d    = 1'b0;
    d_rdata_d  = '0;
    resp_err   = 1'b0;
    resp_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d   = GRANT;
          cnt_d     = '0;
          win_d_d   = grant[GntD];
          last_d_d  = grant[GntD];
          busy_d    = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = grant[GntD] & d_we;
          m_addr_d  = grant[GntD] ? d_addr : f_addr;
          m_wdata_d = grant[GntD] ? d_wdata : '0;
        end
      end
      GRANT: begin
        // m_ack wins over a timeout expiring on the same edge.
        if (m_ack || (cnt_q == CntLast)) begin
          resp_err   = ~m_ack;
          resp_rdata = (m_ack && !m_we_q) ? m_rdata : '0;
          state_d    = RESP;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          m_addr_d   = '0;
          m_wdata_d  = '0;
          if (win_d_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = resp_err;
            d_rdata_d = resp_rdata;
          end else begin
            f_ack_d   = 1'b1;
            f_err_d   = resp_err;
            f_rdata_d = resp_rdata;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b1;
      win_d_q   <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      f_ack_q   <= 1'b0;
      f_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      win_d_q   <= win_d_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      f_ack_q   <= f_ack_d;
      f_err_q   <= f_err_d;
      f_rdata_q <= f_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign f_ack   = f_ack_q;
  assign f_err   = f_err_q;
  assign f_rdata = f_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;

endmodule
